// File: rtl/tdm_demux4_if.sv
// Bundle of the TDM receive lane and the demultiplexed frame outputs.
interface tdm_demux4_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             sync;
    logic             din;
    logic [0:3]       dout;
    logic             frame_valid;
    logic             locked;
    logic [1:0]       slot;
    logic             sync_err;
    logic [CNT_W-1:0] frame_cnt;

    // Transmit/stimulus side: drives the serial lane, observes frames.
    modport master (
        output en,
        output sync,
        output din,
        input  dout,
        input  frame_valid,
        input  locked,
        input  slot,
        input  sync_err,
        input  frame_cnt
    );

    // Receiver side: samples the serial lane, presents parallel frames.
    modport slave (
        input  en,
        input  sync,
        input  din,
        output dout,
        output frame_valid,
        output locked,
        output slot,
        output sync_err,
        output frame_cnt
    );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: serial lane with frame-start marker in,
// one parallel 4-bit frame per completed slot sequence out.
module tdm_demux4 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux4_if.slave  bus
);

    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned FRAME_W = 4;
    localparam int unsigned BUF_W   = 3;

    typedef enum logic {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SLOT_W-1:0]   r_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [0:BUF_W-1]    r_buf;
    logic [0:BUF_W-1]    w_buf_nxt;
    logic [0:FRAME_W-1]  r_dout;
    logic [0:FRAME_W-1]  w_dout_nxt;
    logic                r_frame_valid;
    logic                w_frame_valid_nxt;
    logic                r_sync_err;
    logic                w_sync_err_nxt;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [CNT_W-1:0]    w_frame_cnt_nxt;

    // State, slot pointer, partial-frame buffer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_UNLOCKED;
            r_slot        <= '0;
            r_buf         <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_buf         <= w_buf_nxt;
            r_dout        <= w_dout_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
        end
    end

    // Next-state: a sync restarts the frame at slot 0 (flagging a resync if
    // mid-frame); otherwise a locked receiver walks slots 0..3 and emits on 3.
    always_comb begin
        w_state_nxt       = r_state;
        w_slot_nxt        = r_slot;
        w_buf_nxt         = r_buf;
        w_dout_nxt        = r_dout;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;
        w_frame_cnt_nxt   = r_frame_cnt;

        if (bus.en) begin
            if (bus.sync) begin
                w_state_nxt    = S_LOCKED;
                w_buf_nxt[0]   = bus.din;
                w_slot_nxt     = SLOT_W'(1);
                w_sync_err_nxt = (r_state == S_LOCKED) && (r_slot != '0);
            end else if (r_state == S_LOCKED) begin
                case (r_slot)
                    2'd0: begin
                        w_buf_nxt[0] = bus.din;
                        w_slot_nxt   = SLOT_W'(1);
                    end
                    2'd1: begin
                        w_buf_nxt[1] = bus.din;
                        w_slot_nxt   = SLOT_W'(2);
                    end
                    2'd2: begin
                        w_buf_nxt[2] = bus.din;
                        w_slot_nxt   = SLOT_W'(3);
                    end
                    default: begin
                        w_dout_nxt        = {r_buf[0], r_buf[1], r_buf[2], bus.din};
                        w_frame_valid_nxt = 1'b1;
                        w_slot_nxt        = '0;
                        if (!(&r_frame_cnt)) begin
                            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.dout        = r_dout;
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = (r_state == S_LOCKED);
    assign bus.slot        = r_slot;
    assign bus.sync_err    = r_sync_err;
    assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: two instances (8-bit and 2-bit frame
// counters) share one stimulus stream.
module tb_tdm_demux4;

    logic clk;
    logic rst;
    logic en;
    logic sync;
    logic din;

    int n_checks;
    int n_errors;
    int fv_seen;

    tdm_demux4_if #(.CNT_W(8)) if8 ();
    tdm_demux4_if #(.CNT_W(2)) if2 ();

    assign if8.en   = en;
    assign if8.sync = sync;
    assign if8.din  = din;
    assign if2.en   = en;
    assign if2.sync = sync;
    assign if2.din  = din;

    tdm_demux4 #(.CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    tdm_demux4 #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample just after the edge.
    task automatic step(input logic e, input logic s, input logic d);
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
        check("fv_err_excl", 32'(if8.frame_valid & if8.sync_err), 32'd0);
        if (if8.frame_valid) fv_seen++;
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_dout",   32'(if8.dout),        32'd0);
        check("rst_fv",     32'(if8.frame_valid), 32'd0);
        check("rst_locked", 32'(if8.locked),      32'd0);
        check("rst_slot",   32'(if8.slot),        32'd0);
        check("rst_err",    32'(if8.sync_err),    32'd0);
        check("rst_cnt",    32'(if8.frame_cnt),   32'd0);
        check("rst_cnt2",   32'(if2.frame_cnt),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp_cnt2 [5] = '{1, 2, 3, 3, 3};

    initial begin
        n_checks = 0;
        n_errors = 0;
        fv_seen  = 0;
        rst  = 1'b0;
        en   = 1'b0;
        sync = 1'b0;
        din  = 1'b0;
        #1;
        do_reset();

        // Frame 1010 with sync on slot 0.
        step(1, 1, 1);
        check("t1_slot1",   32'(if8.slot),   32'd1);
        check("t1_locked",  32'(if8.locked), 32'd1);
        step(1, 0, 0);
        step(1, 0, 1);
        check("t1_nofv",    32'(if8.frame_valid), 32'd0);
        step(1, 0, 0);
        check("t1_dout",    32'(if8.dout),        32'hA);
        check("t1_fv",      32'(if8.frame_valid), 32'd1);
        check("t1_cnt",     32'(if8.frame_cnt),   32'd1);
        check("t1_slot0",   32'(if8.slot),        32'd0);
        step(0, 0, 0);
        check("t1_fv_pulse", 32'(if8.frame_valid), 32'd0);
        check("t1_hold",     32'(if8.dout),        32'hA);

        // Free-running second frame 0111 without sync.
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        check("t2_dout",   32'(if8.dout),        32'h7);
        check("t2_fv",     32'(if8.frame_valid), 32'd1);
        check("t2_cnt",    32'(if8.frame_cnt),   32'd2);
        check("t2_locked", 32'(if8.locked),      32'd1);

        // Unlocked: data without sync is ignored.
        do_reset();
        fv_seen = 0;
        for (int i = 0; i < 8; i++) step(1, 0, 1'(i));
        check("t3_locked", 32'(if8.locked),    32'd0);
        check("t3_dout",   32'(if8.dout),      32'd0);
        check("t3_fv",     32'(fv_seen),       32'd0);
        check("t3_slot",   32'(if8.slot),      32'd0);
        check("t3_cnt",    32'(if8.frame_cnt), 32'd0);

        // Resync at slot 2, then at slot 3.
        step(1, 1, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        check("t4_dout0", 32'(if8.dout), 32'h9);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 1, 0);
        check("t4_err",    32'(if8.sync_err),    32'd1);
        check("t4_nofv",   32'(if8.frame_valid), 32'd0);
        check("t4_dhold",  32'(if8.dout),        32'h9);
        check("t4_slot",   32'(if8.slot),        32'd1);
        step(1, 0, 1);
        check("t4_errpulse", 32'(if8.sync_err), 32'd0);
        step(1, 0, 1);
        step(1, 0, 0);
        check("t4_dout1", 32'(if8.dout),        32'h6);
        check("t4_fv1",   32'(if8.frame_valid), 32'd1);
        check("t4_cnt",   32'(if8.frame_cnt),   32'd2);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 1, 1);
        check("t4_err3",   32'(if8.sync_err),    32'd1);
        check("t4_nofv3",  32'(if8.frame_valid), 32'd0);
        check("t4_dhold3", 32'(if8.dout),        32'h6);
        check("t4_cnt3",   32'(if8.frame_cnt),   32'd2);

        // Frame 1100 with 3-cycle en gaps between slots.
        step(1, 1, 1);
        check("t5_err0", 32'(if8.sync_err), 32'd1);
        fv_seen = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        check("t5_slot_gap", 32'(if8.slot), 32'd2);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check("t5_gapfv", 32'(fv_seen), 32'd0);
        step(1, 0, 0);
        check("t5_dout", 32'(if8.dout),        32'hC);
        check("t5_fv",   32'(if8.frame_valid), 32'd1);
        check("t5_cnt",  32'(if8.frame_cnt),   32'd3);

        // Mid-frame reset discards the partial frame; wait for sync again.
        step(1, 0, 1);
        step(1, 0, 1);
        do_reset();
        fv_seen = 0;
        for (int i = 0; i < 4; i++) step(1, 0, 1);
        check("t5_relock", 32'(if8.locked), 32'd0);
        check("t5_refv",   32'(fv_seen),    32'd0);

        // Counter saturation on the 2-bit instance.
        for (int f = 0; f < 5; f++) begin
            step(1, 1, 1);
            step(1, 0, 0);
            step(1, 0, 1);
            step(1, 0, 1);
            check("t6_cnt2", 32'(if2.frame_cnt), 32'(exp_cnt2[f]));
        end
        check("t6_cnt8", 32'(if8.frame_cnt), 32'd5);
        check("t6_dout", 32'(if2.dout),      32'hB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4-to-1 select mux used as a time-division multiplexer.
- Takes one serial lane carrying 4 time slots per frame, with a frame-start marker. Distributes slot i to parallel output bit dout[i].
- Presents each completed frame with a one-cycle valid pulse.
- Sits after a counter-driven mux on a shared wire, so W[0:3] sent by the transmitter reappears as dout[0:3].

Parameters:
- CNT_W, 8, width of the completed-frame counter (saturating).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  slot strobe; din/sync sampled only on edges where en=1
- sync  input  1  frame-start marker, qualified by en; marks current din as slot 0
- din  input  1  serial TDM data
- dout  output  [0:3]  last complete frame; dout[i] = slot i (MSB-first index, same ordering as mux W[0:3])
- frame_valid  output  1  one-cycle pulse when dout updates
- locked  output  1  high once a sync has been seen
- slot  output  [1:0]  slot index expected on the next en sample
- sync_err  output  1  one-cycle pulse when sync arrives at slot != 0
- frame_cnt  output  [CNT_W-1:0]  completed frames; saturates at all-ones

Behaviour:
- Reset (async, rst=1) forces all state and outputs to zero immediately: dout=4'b0000, frame_valid=0, locked=0, slot=0, sync_err=0, frame_cnt=0, and the internal 3-bit slot buffer is cleared.
- Reset asserted mid-frame discards the partial frame. Reception resumes only after the next sync.
- States:
  - UNLOCKED (locked=0): en samples without sync are ignored; slot stays 0.
  - LOCKED: entered on an en=1 & sync=1 edge.
- Sampling, for each edge with en=1 in LOCKED, or a sync edge:
  - Effective slot s = 0 if sync=1, else the current slot.
  - s=0..2: buf[s] <= din; slot <= s+1.
  - s=3: dout <= {buf[0],buf[1],buf[2],din}; frame_valid <= 1 next cycle; slot <= 0; frame_cnt increments unless saturated.
- Latency: dout and frame_valid appear 1 cycle after the edge that samples slot 3. dout holds until the next completed frame.
- en=0: no state change. slot, buffers and dout hold; frame_valid and sync_err deassert.
- Sync arriving at slot 0 in LOCKED is normal: no error.
- Sync arriving at slot 1..3 in LOCKED:
  - sync_err pulses 1 cycle.
  - The partial frame is discarded: dout unchanged, no frame_valid.
  - din is taken as slot 0 of a new frame; slot <= 1.
- Sync with slot 3 expected still counts as a resync. The frame is not completed.
- Sync while UNLOCKED: sets locked, no sync_err, din becomes slot 0.
- Sync is not required on every frame. After slot 3, slot wraps to 0 and reception continues free-running.
- frame_valid and sync_err are never both high.
- frame_cnt wraps never; it holds at 2^CNT_W-1.

Test Plan:
- Reset then sync+din=1, then din=0,1,0 on 3 consecutive en cycles -> one cycle later dout=4'b1010, frame_valid=1 for exactly 1 cycle, frame_cnt=1, slot=0.
- Continue without sync, sending 0,1,1,1 -> dout=4'b0111, frame_cnt=2; locked stays 1.
- Before any sync, toggle din with en=1 for 8 cycles -> locked=0, dout=0, frame_valid never asserted, slot=0.
- Sync at slot 2 of a frame (after bits 1,1) -> sync_err pulse, dout unchanged, slot=1. Next 3 bits complete a new frame normally.
- Insert en=0 gaps of 3 cycles between slots of frame 1,1,0,0 -> dout=4'b1100, with no spurious frame_valid during gaps. Assert rst mid-frame -> all outputs 0 immediately, locked=0.
- With CNT_W=2, send 5 frames -> frame_cnt sequence 1,2,3,3,3.
